// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, clock out
// one command byte on device clock edges and check the device ack.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 2500,
    parameter int START_TIMEOUT  = 375000,
    parameter int XFER_TIMEOUT   = 50000
) (
    input  logic       clk25,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       tx_done,
    output logic       tx_error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_WAIT_FIRST,
        S_BITS,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    localparam logic [18:0] INH_LAST   = 19'(INHIBIT_CYCLES - 1);
    localparam logic [18:0] START_LAST = 19'(START_TIMEOUT - 1);
    localparam logic [18:0] XFER_LAST  = 19'(XFER_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [9:0]  shift_q, shift_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [18:0] to_cnt_q, to_cnt_d;
    logic        clk_oe_q, clk_oe_d;
    logic        data_oe_q, data_oe_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;

    // [0],[1] synchronizer stages, [2] previous synchronized level
    logic [2:0]  clk_sync_q;
    logic [1:0]  data_sync_q;

    logic clk_s;
    logic data_s;
    logic fe;

    assign clk_s  = clk_sync_q[1];
    assign data_s = data_sync_q[1];
    assign fe     = clk_sync_q[2] & ~clk_sync_q[1];

    always_ff @(posedge clk25) begin
        if (rst) begin
            state_q     <= S_IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            to_cnt_q    <= '0;
            clk_oe_q    <= 1'b0;
            data_oe_q   <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            clk_sync_q  <= 3'b111;
            data_sync_q <= 2'b11;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            to_cnt_q    <= to_cnt_d;
            clk_oe_q    <= clk_oe_d;
            data_oe_q   <= data_oe_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            clk_sync_q  <= {clk_sync_q[1:0], ps2_clk_in};
            data_sync_q <= {data_sync_q[0], ps2_data_in};
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        to_cnt_d  = to_cnt_q + 19'd1;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        error_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                to_cnt_d = '0;
                if (tx_valid && ready_q) begin
                    shift_d   = {1'b1, ~^tx_data, tx_data};
                    bit_cnt_d = '0;
                    state_d   = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (to_cnt_q == INH_LAST) begin
                    to_cnt_d = '0;
                    state_d  = S_RTS;
                end
            end
            S_RTS: begin
                to_cnt_d = '0;
                state_d  = S_WAIT_FIRST;
            end
            S_WAIT_FIRST: begin
                if (fe) begin
                    data_oe_d = ~shift_q[0];
                    bit_cnt_d = 4'd1;
                    to_cnt_d  = '0;
                    state_d   = S_BITS;
                end else if (to_cnt_q == START_LAST) begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_BITS: begin
                if (to_cnt_q == XFER_LAST) begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end else if (fe) begin
                    data_oe_d = ~shift_q[bit_cnt_q];
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd9) begin
                        state_d = S_ACK;
                    end
                end
            end
            S_ACK: begin
                if (to_cnt_q == XFER_LAST) begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end else if (fe) begin
                    if (!data_s) begin
                        state_d = S_WAIT_IDLE;
                    end else begin
                        error_d = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (clk_s && data_s) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (to_cnt_q == XFER_LAST) begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered copies of what the next state requires
        clk_oe_d = (state_d == S_INHIBIT) || (state_d == S_RTS);
        if (state_d == S_RTS) begin
            data_oe_d = 1'b1;
        end
        if (state_d == S_IDLE) begin
            data_oe_d = 1'b0;
        end
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
    end

    assign tx_ready    = ready_q;
    assign busy        = busy_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign tx_done     = done_q;
    assign tx_error    = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: keyboard device model on open-drain pads, frame
// reference model and a pulse scoreboard fed by the stimulus side.
module tb_ps2_host_tx;

    localparam int INH   = 16;
    localparam int START = 400;
    localparam int XFER  = 1500;

    typedef struct {
        bit          is_done;
        bit          chk_frame;
        logic [10:0] frame;
    } exp_t;

    logic       clk25 = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       busy;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       tx_done;
    logic       tx_error;

    logic dev_clk_low = 1'b0;
    logic dev_data_low = 1'b0;

    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .START_TIMEOUT (START),
        .XFER_TIMEOUT  (XFER)
    ) dut (
        .clk25      (clk25),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .tx_done    (tx_done),
        .tx_error   (tx_error)
    );

    always #20 clk25 = ~clk25;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int acc_cnt = 0;
    int acc_cyc = -1;
    int pulse_cyc = -1;
    int rel_cyc = 0;
    bit prev_pulse = 1'b0;
    logic [10:0] dev_frame = '0;
    exp_t exp_q[$];
    exp_t mon_e;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Frame as the device sees it on rising edges: start, data LSB first,
    // odd parity, stop.
    function automatic logic [10:0] ref_frame(input logic [7:0] d);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1+i] = d[i];
        f[9]  = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
        f[10] = 1'b1;
        return f;
    endfunction

    always @(posedge clk25) begin
        cyc++;
        if (!rst && tx_valid && tx_ready) begin
            acc_cnt++;
            acc_cyc = cyc;
        end
    end

    always @(negedge clk25) begin
        if (prev_pulse) check("pulse_one_cycle", tx_done | tx_error, 0);
        prev_pulse = tx_done | tx_error;
        if (tx_done || tx_error) begin
            pulse_cyc = cyc;
            check("done_err_exclusive", tx_done & tx_error, 0);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {tx_done, tx_error}, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("pulse_is_done", tx_done, mon_e.is_done);
                check("ready_at_pulse", tx_ready, 1);
                check("oe_at_pulse", {ps2_clk_oe, ps2_data_oe}, 0);
                if (mon_e.chk_frame && tx_done)
                    check("frame", dev_frame, mon_e.frame);
            end
        end
    end

    task automatic expect_resp(input logic [7:0] d, input bit done);
        exp_t e;
        e.is_done   = done;
        e.chk_frame = 1'b1;
        e.frame     = ref_frame(d);
        exp_q.push_back(e);
    endtask

    // Called in the first cycle after an accept.
    task automatic measure();
        int inh = 0;
        int rts = 0;
        check("ready_low", tx_ready, 0);
        check("busy_high", busy, 1);
        while (ps2_clk_oe && !ps2_data_oe && inh < 4 * INH) begin
            inh++;
            @(negedge clk25);
        end
        check("inhibit_width", inh, INH);
        while (ps2_clk_oe && ps2_data_oe && rts < 8) begin
            rts++;
            @(negedge clk25);
        end
        check("rts_width", rts, 1);
        check("release_state", {ps2_clk_oe, ps2_data_oe}, 2'b01);
        rel_cyc = cyc;
    endtask

    task automatic send(input logic [7:0] d, input bit hold);
        @(negedge clk25);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk25);
        if (!hold) tx_valid = 1'b0;
        measure();
    endtask

    // mode 0: ack, 1: no ack, 2: never clocks; abort>0 stops after
    // that many clock pulses.
    task automatic dev_run(input int half, input int mode, input int abort);
        if (mode == 2) return;
        repeat (half) @(negedge clk25);
        dev_frame[0] = ps2_data_in;
        for (int k = 1; k <= 10; k++) begin
            if (abort > 0 && k > abort) return;
            dev_clk_low = 1'b1;
            repeat (half) @(negedge clk25);
            dev_clk_low = 1'b0;
            @(negedge clk25);
            dev_frame[k] = ps2_data_in;
            repeat (half - 1) @(negedge clk25);
        end
        if (mode == 0) dev_data_low = 1'b1;
        repeat (half) @(negedge clk25);
        dev_clk_low = 1'b1;
        repeat (half) @(negedge clk25);
        dev_clk_low = 1'b0;
        repeat (2) @(negedge clk25);
        dev_data_low = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk25);
            #1;
            n++;
        end
        check("response_seen", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int a0;
        repeat (3) @(negedge clk25);
        rst = 1'b0;
        check("rst_clk_oe", ps2_clk_oe, 0);
        check("rst_data_oe", ps2_data_oe, 0);
        check("rst_ready", tx_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_pulses", {tx_done, tx_error}, 0);

        expect_resp(8'hED, 1'b1);
        send(8'hED, 1'b0);
        dev_run(10, 0, 0);
        wait_drain(60);

        expect_resp(8'hF4, 1'b1);
        send(8'hF4, 1'b0);
        dev_run(8, 0, 0);
        wait_drain(60);

        expect_resp(8'h5A, 1'b0);
        send(8'h5A, 1'b0);
        dev_run(8, 2, 0);
        wait_drain(START + 50);
        check("start_timeout_cycles", pulse_cyc - rel_cyc, START);

        expect_resp(8'hED, 1'b0);
        send(8'hED, 1'b0);
        dev_run(9, 1, 0);
        wait_drain(60);

        send(8'hFF, 1'b0);
        dev_run(8, 0, 5);
        rst = 1'b1;
        @(negedge clk25);
        rst = 1'b0;
        check("midrst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
        check("midrst_ready", tx_ready, 1);
        check("midrst_busy", busy, 0);
        repeat (40) @(negedge clk25);

        expect_resp(8'h01, 1'b1);
        send(8'h01, 1'b0);
        dev_run(7, 0, 0);
        wait_drain(60);

        a0 = acc_cnt;
        expect_resp(8'hAA, 1'b1);
        send(8'hAA, 1'b1);
        dev_run(8, 0, 0);
        check("held_single_accept", acc_cnt - a0, 1);
        wait_drain(60);
        @(negedge clk25);
        tx_valid = 1'b0;
        check("held_second_accept", acc_cnt - a0, 2);
        check("accept_in_done_cycle", acc_cyc, pulse_cyc + 1);
        expect_resp(8'hAA, 1'b1);
        measure();
        dev_run(8, 0, 0);
        wait_drain(60);

        for (int i = 0; i < 8; i++) begin
            logic [7:0] d;
            int mode;
            int half;
            d    = 8'($urandom);
            mode = $urandom_range(0, 1);
            half = $urandom_range(5, 12);
            expect_resp(d, mode == 0);
            send(d, 1'b0);
            dev_run(half, mode, 0);
            wait_drain(80);
        end

        repeat (20) @(negedge clk25);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #(40 * 80000);
        $display("FAIL watchdog: simulation did not finish, expected end");
        $fatal(1);
    end

endmodule
